// File: rtl/i2c_target.sv
// I2C target emulating PCA9685-style register access. SCL/SDA are oversampled on clk_i,
// and the target exposes a single-cycle register-file port to the PWM core.
module i2c_target #(
  parameter logic [6:0] ADDRESS     = 7'h40,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  inout  wire        sda_io,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_t;

  state_t            state_reg;
  logic [STAGES-1:0] scl_sync_reg;
  logic [STAGES-1:0] sda_sync_reg;
  logic              scl_d_reg;
  logic              sda_d_reg;
  logic [7:0]        shift_reg;
  logic [3:0]        bit_cnt_reg;
  logic              rw_reg;
  logic              sda_drive_reg;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_evt;
  logic       stop_evt;
  logic [7:0] byte_in;

  // Synchronisers idle high so that leaving reset on a quiet bus creates no edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[STAGES-2:0], scl_i};
      sda_sync_reg <= {sda_sync_reg[STAGES-2:0], sda_io};
      scl_d_reg    <= scl_s;
      sda_d_reg    <= sda_s;
    end
  end

  assign scl_s     = scl_sync_reg[STAGES-1];
  assign sda_s     = sda_sync_reg[STAGES-1];
  assign scl_rise  = scl_s & ~scl_d_reg;
  assign scl_fall  = ~scl_s & scl_d_reg;
  assign start_evt = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
  assign stop_evt  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;
  assign byte_in   = {shift_reg[6:0], sda_s};

  // A bus event releases SDA in the same cycle it is seen, ahead of the registered drive.
  assign sda_io = (sda_drive_reg && !start_evt && !stop_evt) ? 1'b0 : 1'bz;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      shift_reg     <= 8'h00;
      bit_cnt_reg   <= 4'd0;
      rw_reg        <= 1'b0;
      sda_drive_reg <= 1'b0;
      reg_addr_o    <= 8'h00;
      reg_wdata_o   <= 8'h00;
      reg_we_o      <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      reg_we_o <= 1'b0;
      if (reg_we_o) begin
        reg_addr_o <= reg_addr_o + 8'd1;
      end

      if (start_evt) begin
        state_reg     <= ADDR;
        bit_cnt_reg   <= 4'd0;
        shift_reg     <= 8'h00;
        sda_drive_reg <= 1'b0;
        busy_o        <= 1'b0;
      end else if (stop_evt) begin
        state_reg     <= IDLE;
        bit_cnt_reg   <= 4'd0;
        sda_drive_reg <= 1'b0;
        busy_o        <= 1'b0;
      end else begin
        case (state_reg)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shift_reg   <= byte_in;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                bit_cnt_reg <= 4'd0;
                case (state_reg)
                  ADDR: begin
                    if (byte_in[7:1] == ADDRESS) begin
                      state_reg <= ADDR_ACK;
                      busy_o    <= 1'b1;
                      rw_reg    <= byte_in[0];
                    end else begin
                      state_reg <= IGNORE;
                    end
                  end
                  PTR: begin
                    reg_addr_o <= byte_in;
                    state_reg  <= PTR_ACK;
                  end
                  default: begin
                    reg_wdata_o <= byte_in;
                    reg_we_o    <= 1'b1;
                    state_reg   <= WDATA_ACK;
                  end
                endcase
              end
            end
          end

          // First falling edge starts the ACK, the next one ends it.
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_drive_reg) begin
                sda_drive_reg <= 1'b1;
              end else if (state_reg == ADDR_ACK && rw_reg) begin
                shift_reg     <= reg_rdata_i;
                sda_drive_reg <= ~reg_rdata_i[7];
                bit_cnt_reg   <= 4'd0;
                state_reg     <= RDATA;
              end else begin
                sda_drive_reg <= 1'b0;
                bit_cnt_reg   <= 4'd0;
                state_reg     <= (state_reg == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end

          RDATA: begin
            if (scl_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              shift_reg   <= {shift_reg[6:0], 1'b0};
            end else if (scl_fall) begin
              if (bit_cnt_reg == 4'd8) begin
                bit_cnt_reg   <= 4'd0;
                sda_drive_reg <= 1'b0;
                state_reg     <= RDATA_ACK;
              end else begin
                sda_drive_reg <= ~shift_reg[7];
              end
            end
          end

          RDATA_ACK: begin
            if (scl_rise) begin
              reg_addr_o <= reg_addr_o + 8'd1;
              if (sda_s) begin
                state_reg <= IGNORE;
                busy_o    <= 1'b0;
              end
            end else if (scl_fall) begin
              shift_reg     <= reg_rdata_i;
              sda_drive_reg <= ~reg_rdata_i[7];
              bit_cnt_reg   <= 4'd0;
              state_reg     <= RDATA;
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed and randomized bus transactions against i2c_target, with a transaction-level
// model of the expected register writes, read bytes and pointer.
module tb_i2c_target;

  localparam int Q = 6;
  localparam int H = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_low;
  wire        sda;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_we;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  model_ptr;

  always #5 clk = ~clk;

  pullup (sda);
  assign sda       = sda_low ? 1'b0 : 1'bz;
  assign reg_rdata = reg_addr ^ 8'hA5;

  i2c_target #(
    .ADDRESS    (7'h40),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl),
    .sda_io     (sda),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_we_o   (reg_we),
    .reg_rdata_i(reg_rdata),
    .busy_o     (busy)
  );

  always @(negedge clk) begin
    if (reg_we) obs_q.push_back({reg_addr, reg_wdata});
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    sda_low = 1'b0;
    clks(Q);
    scl = 1'b1;
    clks(H);
    sda_low = 1'b1;
    clks(H);
    scl = 1'b0;
    clks(2);
  endtask

  task automatic bus_stop();
    clks(Q);
    sda_low = 1'b1;
    clks(Q);
    scl = 1'b1;
    clks(H);
    sda_low = 1'b0;
    clks(H);
  endtask

  task automatic send_bit(input logic b);
    clks(Q);
    sda_low = ~b;
    clks(Q);
    scl = 1'b1;
    clks(H);
    scl = 1'b0;
    clks(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    clks(Q);
    sda_low = 1'b0;
    clks(Q);
    scl = 1'b1;
    clks(H / 2);
    acked = (sda === 1'b0);
    clks(H / 2);
    scl = 1'b0;
    clks(2);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic master_ack);
    logic [7:0] v;
    sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clks(2 * Q);
      scl = 1'b1;
      clks(H / 2);
      v[i] = sda;
      clks(H / 2);
      scl = 1'b0;
      clks(2);
    end
    clks(Q);
    sda_low = master_ack;
    clks(Q);
    scl = 1'b1;
    clks(H);
    scl = 1'b0;
    clks(2);
    sda_low = 1'b0;
    b = v;
  endtask

  task automatic compare_writes();
    int n;
    check("we_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("we_addr_data", obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wr_txn(input logic [6:0] addr7, input logic [7:0] p,
                        input logic [7:0] d [4], input int n);
    logic ack;
    logic match;
    match = (addr7 == 7'h40);
    bus_start();
    write_byte({addr7, 1'b0}, ack);
    check("wr_addr_ack", ack, match);
    check("busy_after_addr", busy, match);
    write_byte(p, ack);
    check("wr_ptr_ack", ack, match);
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], ack);
      check("wr_data_ack", ack, match);
      if (match) exp_q.push_back({p + 8'(i), d[i]});
    end
    bus_stop();
    clks(4);
    check("busy_after_stop", busy, 1'b0);
    if (match) model_ptr = p + 8'(n);
    check("ptr_after_wr", reg_addr, model_ptr);
    compare_writes();
    $display("write addr=0x%02h ptr=0x%02h len=%0d final_ptr=0x%02h", addr7, p, n, reg_addr);
  endtask

  task automatic rd_txn(input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] b;
    bus_start();
    write_byte(8'h80, ack);
    check("rd_waddr_ack", ack, 1'b1);
    write_byte(p, ack);
    check("rd_ptr_ack", ack, 1'b1);
    bus_start();
    write_byte(8'h81, ack);
    check("rd_raddr_ack", ack, 1'b1);
    check("busy_in_read", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      read_byte(b, i < n - 1);
      check("rd_data", b, (p + 8'(i)) ^ 8'hA5);
    end
    check("busy_after_nack", busy, 1'b0);
    bus_stop();
    model_ptr = p + 8'(n);
    check("ptr_after_rd", reg_addr, model_ptr);
    compare_writes();
    $display("read ptr=0x%02h len=%0d final_ptr=0x%02h", p, n, reg_addr);
  endtask

  initial begin
    logic       ack;
    logic [7:0] b;
    logic [7:0] d [4];
    logic [6:0] a7;
    int         n;

    rst     = 1'b1;
    scl     = 1'b1;
    sda_low = 1'b0;
    clks(4);
    check("rst_addr", reg_addr, 8'h00);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_we", reg_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", sda, 1'b1);
    rst = 1'b0;
    model_ptr = 8'h00;
    clks(4);

    wr_txn(7'h40, 8'h06, '{8'h5A, 8'h3C, 8'h00, 8'h00}, 2);
    check("t1_wdata", reg_wdata, 8'h3C);
    rd_txn(8'h0F, 2);
    wr_txn(7'h41, 8'h06, '{8'h11, 8'h00, 8'h00, 8'h00}, 1);
    wr_txn(7'h40, 8'hFF, '{8'h01, 8'h02, 8'h00, 8'h00}, 2);

    // Abort mid-byte, then a fresh transaction must still be ACKed.
    bus_start();
    write_byte(8'h80, ack);
    check("ab_addr_ack", ack, 1'b1);
    write_byte(8'h20, ack);
    check("ab_ptr_ack", ack, 1'b1);
    model_ptr = 8'h20;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    bus_stop();
    clks(4);
    check("ab_busy", busy, 1'b0);
    check("ab_ptr", reg_addr, model_ptr);
    compare_writes();
    bus_start();
    write_byte(8'h80, ack);
    check("ab_again_ack", ack, 1'b1);
    check("ab_again_busy", busy, 1'b1);
    bus_stop();
    $display("abort ptr=0x%02h busy=%0d", reg_addr, busy);

    // Reset while the target drives a 0 read bit.
    bus_start();
    write_byte(8'h80, ack);
    write_byte(8'hA5, ack);
    bus_start();
    write_byte(8'h81, ack);
    check("rr_addr_ack", ack, 1'b1);
    clks(3);
    check("rr_bit_driven", sda, 1'b0);
    rst = 1'b1;
    clks(1);
    check("rr_sda_released", sda, 1'b1);
    check("rr_addr", reg_addr, 8'h00);
    check("rr_wdata", reg_wdata, 8'h00);
    check("rr_we", reg_we, 1'b0);
    check("rr_busy", busy, 1'b0);
    clks(2);
    rst = 1'b0;
    model_ptr = 8'h00;
    obs_q.delete();
    read_byte(b, 1'b0);
    check("rr_idle_bus", b, 8'hFF);
    check("rr_idle_busy", busy, 1'b0);
    bus_stop();
    check("rr_idle_ptr", reg_addr, model_ptr);
    compare_writes();
    $display("reset-mid-read idle_byte=0x%02h", b);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      n = $urandom_range(1, 4);
      wr_txn(7'h40, 8'($urandom), d, n);
      rd_txn(8'($urandom), $urandom_range(1, 3));
      a7 = 7'($urandom);
      if (a7 == 7'h40) a7 = 7'h41;
      wr_txn(a7, 8'($urandom), d, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
